elevator: RTL and testbench

Single-car elevator controller for up to 16 floors. Every clock it latches the floor request on req_floor into a pending-request vector. It moves the car one floor at a time using SCAN (continue in the current direction while requests remain ahead, otherwise reverse). It opens the door for a fixed time at each requested floor. It is a top-level leaf block with no downstream handshake; all status is exposed as registered outputs.

---
 rtl/elevator.sv | 154 +++++++++++++++
 tb/tb_elevator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator.sv
// Single-car SCAN elevator controller: latches floor requests into a pending vector,
// steps the car one floor per FLOOR_CYCLES clocks and holds the door for DOOR_CYCLES clocks.
module elevator #(
  parameter int NUM_FLOORS   = 16,
  parameter int FLOOR_CYCLES = 2,
  parameter int DOOR_CYCLES  = 3
) (
  input  logic [3:0]  req_floor,
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  current_floor,
  output logic [15:0] pending,
  output logic        moving,
  output logic        dir_up,
  output logic        door_open
);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR_OPEN} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_floor, w_floor_nxt;
  logic [15:0] r_pending, w_pending_nxt, w_set, w_clr;
  logic        r_dir_up, w_dir_nxt;
  logic [15:0] r_travel_cnt, w_travel_nxt;
  logic [15:0] r_door_cnt, w_door_nxt;
  logic        r_moving, r_door_open;
  logic [3:0]  w_step_floor;
  logic        w_above, w_below, w_above_s, w_below_s, w_at_top, w_at_bottom;

  function automatic logic any_above(input logic [15:0] p, input logic [3:0] f);
    any_above = 1'b0;
    for (int i = 0; i < 16; i++)
      if (p[i] && (4'(i) > f)) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [15:0] p, input logic [3:0] f);
    any_below = 1'b0;
    for (int i = 0; i < 16; i++)
      if (p[i] && (4'(i) < f)) any_below = 1'b1;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_floor_nxt  = r_floor;
    w_dir_nxt    = r_dir_up;
    w_travel_nxt = r_travel_cnt;
    w_door_nxt   = r_door_cnt;
    w_set        = '0;
    w_clr        = '0;
    w_at_top     = (int'(r_floor) >= NUM_FLOORS - 1);
    w_at_bottom  = (r_floor == 4'd0);
    w_step_floor = r_floor;
    if (r_state == ST_MOVE_UP && !w_at_top)
      w_step_floor = r_floor + 4'd1;
    else if (r_state == ST_MOVE_DOWN && !w_at_bottom)
      w_step_floor = r_floor - 4'd1;
    w_above   = any_above(r_pending, r_floor);
    w_below   = any_below(r_pending, r_floor);
    w_above_s = any_above(r_pending, w_step_floor);
    w_below_s = any_below(r_pending, w_step_floor);

    // A request for the floor the car is parked at (door open or idle) is already served.
    if (int'(req_floor) < NUM_FLOORS &&
        !(req_floor == r_floor && (r_state == ST_IDLE || r_state == ST_DOOR_OPEN)))
      w_set[req_floor] = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_travel_nxt = '0;
        w_door_nxt   = '0;
        if (w_above && (r_dir_up || !w_below)) begin
          w_state_nxt = ST_MOVE_UP;
          w_dir_nxt   = 1'b1;
        end else if (w_below) begin
          w_state_nxt = ST_MOVE_DOWN;
          w_dir_nxt   = 1'b0;
        end
      end
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (r_travel_cnt == 16'(FLOOR_CYCLES - 1)) begin
          w_travel_nxt = '0;
          w_floor_nxt  = w_step_floor;
          if (r_pending[w_step_floor]) begin
            w_clr[w_step_floor] = 1'b1;
            w_state_nxt         = ST_DOOR_OPEN;
            w_door_nxt          = '0;
          end else if (r_state == ST_MOVE_UP ? w_above_s : w_below_s) begin
            w_state_nxt = r_state;
          end else if (r_state == ST_MOVE_UP ? w_below_s : w_above_s) begin
            w_state_nxt = (r_state == ST_MOVE_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
            w_dir_nxt   = ~r_dir_up;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_travel_nxt = r_travel_cnt + 16'd1;
        end
      end
      ST_DOOR_OPEN: begin
        if (r_door_cnt == 16'(DOOR_CYCLES - 1)) begin
          w_door_nxt = '0;
          if (r_dir_up && w_above) begin
            w_state_nxt = ST_MOVE_UP;
          end else if (!r_dir_up && w_below) begin
            w_state_nxt = ST_MOVE_DOWN;
          end else if (w_above) begin
            w_state_nxt = ST_MOVE_UP;
            w_dir_nxt   = 1'b1;
          end else if (w_below) begin
            w_state_nxt = ST_MOVE_DOWN;
            w_dir_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_door_nxt = r_door_cnt + 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The arrival clear wins over a same-cycle request for that floor.
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_floor      <= '0;
      r_pending    <= '0;
      r_dir_up     <= 1'b1;
      r_travel_cnt <= '0;
      r_door_cnt   <= '0;
      r_moving     <= 1'b0;
      r_door_open  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_floor      <= w_floor_nxt;
      r_pending    <= w_pending_nxt;
      r_dir_up     <= w_dir_nxt;
      r_travel_cnt <= w_travel_nxt;
      r_door_cnt   <= w_door_nxt;
      r_moving     <= (w_state_nxt == ST_MOVE_UP) || (w_state_nxt == ST_MOVE_DOWN);
      r_door_open  <= (w_state_nxt == ST_DOOR_OPEN);
    end
  end

  assign current_floor = r_floor;
  assign pending       = r_pending;
  assign moving        = r_moving;
  assign dir_up        = r_dir_up;
  assign door_open     = r_door_open;

endmodule

// File: tb/tb_elevator.sv
// Bench for elevator: a vector table for the single-request trip plus hand-written
// sequences for SCAN ordering, absorbed requests, mid-travel reset and an 8-floor car.
module tb_elevator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_floor = 4'd0;
  logic [3:0]  current_floor;
  logic [15:0] pending;
  logic        moving, dir_up, door_open;

  logic        rst8 = 1'b1;
  logic [3:0]  req8 = 4'd0;
  logic [3:0]  floor8;
  logic [15:0] pend8;
  logic        mov8, dir8, door8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    int          cycles;
    logic [3:0]  floor;
    logic [15:0] pend;
    logic        mov;
    logic        dir;
    logic        door;
  } vec_t;

  vec_t vt[9];

  elevator dut (
    .req_floor(req_floor), .clk(clk), .rst(rst),
    .current_floor(current_floor), .pending(pending),
    .moving(moving), .dir_up(dir_up), .door_open(door_open)
  );

  elevator #(.NUM_FLOORS(8)) dut8 (
    .req_floor(req8), .clk(clk), .rst(rst8),
    .current_floor(floor8), .pending(pend8),
    .moving(mov8), .dir_up(dir8), .door_open(door8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_floor = 4'd0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic do_reset8();
    req8 = 4'd12;
    rst8 = 1'b1;
    step(1);
    rst8 = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic       exp_dir_q[$];
  logic       got_dir_q[$];
  int         len_q[$];

  initial begin
    int  len;
    int  bad;
    int  max_fl;
    int  k;
    logic prev;
    logic [3:0] e;

    vt[0] = '{4'd6, 1, 4'd0, 16'h0040, 1'b0, 1'b1, 1'b0};
    vt[1] = '{4'd6, 1, 4'd0, 16'h0040, 1'b1, 1'b1, 1'b0};
    vt[2] = '{4'd6, 2, 4'd1, 16'h0040, 1'b1, 1'b1, 1'b0};
    vt[3] = '{4'd6, 4, 4'd3, 16'h0040, 1'b1, 1'b1, 1'b0};
    vt[4] = '{4'd6, 4, 4'd5, 16'h0040, 1'b1, 1'b1, 1'b0};
    vt[5] = '{4'd6, 2, 4'd6, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[6] = '{4'd6, 2, 4'd6, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[7] = '{4'd6, 1, 4'd6, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[8] = '{4'd6, 5, 4'd6, 16'h0000, 1'b0, 1'b1, 1'b0};

    // Reset state
    do_reset();
    rst8 = 1'b0;
    chk("rst_floor",   32'(current_floor), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_moving",  32'(moving), 32'd0);
    chk("rst_dir_up",  32'(dir_up), 32'd1);
    chk("rst_door",    32'(door_open), 32'd0);

    // Test 1: single request to floor 6, table-driven
    for (int i = 0; i < 9; i++) begin
      req_floor = vt[i].req;
      step(vt[i].cycles);
      chk($sformatf("t1_v%0d_floor", i), 32'(current_floor), 32'(vt[i].floor));
      chk($sformatf("t1_v%0d_pending", i), 32'(pending), 32'(vt[i].pend));
      chk($sformatf("t1_v%0d_moving", i), 32'(moving), 32'(vt[i].mov));
      chk($sformatf("t1_v%0d_dir_up", i), 32'(dir_up), 32'(vt[i].dir));
      chk($sformatf("t1_v%0d_door", i), 32'(door_open), 32'(vt[i].door));
    end

    // Test 2: SCAN ordering 1,5,6 then reverse to 0
    do_reset();
    exp_q = '{4'd1, 4'd5, 4'd6, 4'd0};
    exp_dir_q = '{1'b1, 1'b1, 1'b1, 1'b0};
    got_q.delete(); got_dir_q.delete(); len_q.delete();
    prev = 1'b0;
    len = 0;
    for (int c = 1; c <= 300 && len_q.size() < 4; c++) begin
      if (c <= 2) req_floor = 4'd6;
      else if (c == 3) req_floor = 4'd1;
      else if (c == 4) req_floor = 4'd5;
      else req_floor = 4'd0;
      step(1);
      if (c == 2) chk("t2_pending_c2", 32'(pending), 32'h0040);
      if (c == 3) chk("t2_pending_c3", 32'(pending), 32'h0042);
      if (c == 5) chk("t2_pending_c5", 32'(pending), 32'h0061);
      if (door_open && !prev) begin
        got_q.push_back(current_floor);
        got_dir_q.push_back(dir_up);
        len = 1;
      end else if (door_open) begin
        len++;
      end else if (prev) begin
        len_q.push_back(len);
      end
      prev = door_open;
    end
    chk("t2_stop_count", 32'(len_q.size()), 32'd4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("t2_stop_floor", 32'(got_q.pop_front()), 32'(e));
      chk("t2_stop_dir", 32'(got_dir_q.pop_front()), 32'(exp_dir_q.pop_front()));
    end
    while (len_q.size() > 0) chk("t2_door_len", 32'(len_q.pop_front()), 32'd3);
    chk("t2_end_floor",   32'(current_floor), 32'd0);
    chk("t2_end_pending", 32'(pending), 32'd0);
    chk("t2_end_moving",  32'(moving), 32'd0);
    chk("t2_end_dir_up",  32'(dir_up), 32'd0);

    // Test 3: request for the current floor while idle is absorbed
    req_floor = 4'd0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (pending != 16'h0 || moving || door_open || current_floor != 4'd0) bad++;
    end
    chk("t3_quiet_cycles", 32'(bad), 32'd0);

    // Test 4: reset mid-travel abandons the trip
    do_reset();
    req_floor = 4'd6;
    k = 0;
    while (k < 60 && current_floor != 4'd3) begin
      step(1);
      k++;
    end
    chk("t4_reached_3", 32'(current_floor), 32'd3);
    chk("t4_moving_at_3", 32'(moving), 32'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_floor = 4'd0;
    chk("t4_floor",   32'(current_floor), 32'd0);
    chk("t4_pending", 32'(pending), 32'd0);
    chk("t4_moving",  32'(moving), 32'd0);
    chk("t4_door",    32'(door_open), 32'd0);
    step(3);
    chk("t4_still_idle", 32'({moving, door_open, current_floor}), 32'd0);

    // Test 5: 8-floor car ignores out-of-range requests, tops out at 7
    do_reset8();
    req8 = 4'd12;
    step(5);
    chk("t5_oor_pending", 32'(pend8), 32'd0);
    chk("t5_oor_moving",  32'(mov8), 32'd0);
    req8 = 4'd7;
    step(1);
    chk("t5_pending_7", 32'(pend8), 32'h0080);
    req8 = 4'd12;
    max_fl = 0;
    k = 0;
    while (k < 100 && !door8) begin
      step(1);
      if (int'(floor8) > max_fl) max_fl = int'(floor8);
      k++;
    end
    chk("t5_door_floor", 32'(floor8), 32'd7);
    chk("t5_door_open",  32'(door8), 32'd1);
    step(4);
    if (int'(floor8) > max_fl) max_fl = int'(floor8);
    chk("t5_max_floor", 32'(max_fl), 32'd7);
    chk("t5_end_idle",  32'({mov8, door8, floor8}), 32'h07);
    chk("t5_end_pending", 32'(pend8), 32'd0);

    // Test 6: at floor 4 going up, requests 2 and 7 during the door -> up first
    do_reset8();
    req8 = 4'd4;
    step(1);
    req8 = 4'd12;
    k = 0;
    while (k < 100 && !door8) begin
      step(1);
      k++;
    end
    chk("t6_at_4",   32'(floor8), 32'd4);
    chk("t6_dir_up", 32'(dir8), 32'd1);
    req8 = 4'd2;
    step(1);
    req8 = 4'd7;
    step(1);
    req8 = 4'd12;
    chk("t6_pending", 32'(pend8), 32'h0084);
    exp_q = '{4'd7, 4'd2};
    got_q.delete();
    prev = door8;
    k = 0;
    while (k < 200 && got_q.size() < 2) begin
      step(1);
      if (door8 && !prev) got_q.push_back(floor8);
      prev = door8;
      k++;
    end
    chk("t6_stop_count", 32'(got_q.size()), 32'd2);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("t6_stop_floor", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    step(4);
    chk("t6_end", 32'({pend8, mov8, door8, floor8}), 32'h002);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
